// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: active-low hex glyphs and index sizing.
// Latency: none (package only).
// Backpressure: none (package only).
package seg7_pkg;

    // Active-low glyphs, bit0=a .. bit6=g; a 0 bit lights that segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit index width; a single-digit display still gets a 1-bit index.
    function automatic int idx_width(input int num_digits);
        return (num_digits <= 1) ? 1 : $clog2(num_digits);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle of the scan driver: load handshake, display controls and panel outputs.
// Latency: none (wiring only).
// Backpressure: none; load is a strobe, pending tells the host a staged value is still waiting.
// Ports: value/dp_in/blank_mask/load/enable from host; seg/dp_n/an/frame_done/pending to host.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    load;
    logic                    enable;
    logic [6:0]              seg;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;
    logic                    pending;

    modport master (
        output value, dp_in, blank_mask, load, enable,
        input  seg, dp_n, an, frame_done, pending
    );

    modport slave (
        input  value, dp_in, blank_mask, load, enable,
        output seg, dp_n, an, frame_done, pending
    );
endinterface

// File: rtl/seg7_hex_lut.sv
// Hex nibble to active-low seven-segment glyph decoder.
// Latency: combinational.
// Backpressure: none.
// Ports: nibble (4-bit in), seg (7-bit active-low out, bit0=a .. bit6=g).
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode hex display driver with double-buffered load and digit blanking.
// Latency: an/seg/dp_n registered one cycle after the scan index; loads commit at the next frame end.
// Backpressure: none; load always accepted (last-wins), pending=1 while staged data awaits commit.
// Ports: clk, rst_n (async active-low), bus (seg7_scan_driver_if.slave).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_BLANK    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] staged_val;
    logic [NUM_DIGITS-1:0]   staged_dp;
    logic [NUM_DIGITS-1:0]   staged_blank;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic                    pending_q;

    logic [NUM_DIGITS-1:0]   lz_vec;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_lz;
    logic                    zero_run;
    logic                    blanked;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [6:0]              lut_seg;

    logic [6:0]              seg_q;
    logic                    dp_n_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_done_q;

    always_comb begin
        tick      = bus.enable && (presc == PRESC_LAST);
        frame_end = tick && (idx == IDX_LAST);
    end

    // Prescaler and digit index; both are held at zero while the display is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (!bus.enable) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Staged register takes every load; the shadow only changes at a frame end so a
    // digit never changes mid-frame. A load landing on the frame end bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_val   <= '0;
            staged_dp    <= '0;
            staged_blank <= '0;
            shadow_val   <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (bus.load) begin
                staged_val   <= bus.value;
                staged_dp    <= bus.dp_in;
                staged_blank <= bus.blank_mask;
            end
            if (frame_end) begin
                if (bus.load) begin
                    shadow_val   <= bus.value;
                    shadow_dp    <= bus.dp_in;
                    shadow_blank <= bus.blank_mask;
                end else if (pending_q) begin
                    shadow_val   <= staged_val;
                    shadow_dp    <= staged_dp;
                    shadow_blank <= staged_blank;
                end
                pending_q <= 1'b0;
            end else if (bus.load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Leading-zero map: scan from the top digit down while every nibble seen is zero.
    // Digit 0 is excluded so an all-zero value still shows a single "0".
    always_comb begin
        lz_vec    = '0;
        zero_run  = 1'b1;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        an_next   = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run  = zero_run && (shadow_val[4*k +: 4] == 4'h0);
            lz_vec[k] = zero_run && (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib    = shadow_val[4*k +: 4];
                cur_dp     = shadow_dp[k];
                cur_blank  = shadow_blank[k];
                cur_lz     = lz_vec[k];
                an_next[k] = 1'b0;
            end
        end
        blanked = cur_blank || ((LZ_BLANK != 0) && cur_lz);
    end

    seg7_hex_lut u_hex_lut (
        .nibble (cur_nib),
        .seg    (lut_seg)
    );

    // Output stage: an, seg and dp_n share one register stage so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (!bus.enable) begin
                an_q   <= '1;
                seg_q  <= SEG_BLANK;
                dp_n_q <= 1'b1;
            end else begin
                an_q   <= an_next;
                seg_q  <= blanked ? SEG_BLANK : lut_seg;
                dp_n_q <= blanked ? 1'b1 : ~cur_dp;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;

endmodule
